// File: rtl/cpu_sequencer.sv
// Two-cycle fetch/execute sequencer for a 4-bit accumulator datapath.
// Strobes are decoded combinationally in EXEC so the datapath captures on the same edge.
module cpu_sequencer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       run,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       alu_carry,
  output logic       select_a,
  output logic       select_b,
  output logic       load0,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic [3:0] im,
  output logic       busy,
  output logic       carry_flag
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_JMP    = 4'b1111;
  localparam logic [3:0] OP_JNC    = 4'b1110;

  // {select_b,select_a} encodings
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       cf_q, cf_d;

  logic [3:0] ld;
  logic [1:0] sel;
  logic [3:0] im_o;
  logic [3:0] op, imm;

  assign op  = ir_q[7:4];
  assign imm = ir_q[3:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cf_d    = cf_q;
    ld      = 4'b0000;
    sel     = SEL_A;
    im_o    = 4'h0;
    case (state_q)
      IDLE:  if (run) state_d = FETCH;
      FETCH: begin
        ir_d    = rom_data;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = run ? FETCH : IDLE;
        pc_d    = pc_q + 4'd1;
        // JNC reads cf_q, i.e. the flag as it stood before this edge
        case (op)
          OP_ADD_A:  begin sel = SEL_A;    im_o = imm; ld[0] = 1'b1; cf_d = alu_carry; end
          OP_ADD_B:  begin sel = SEL_B;    im_o = imm; ld[1] = 1'b1; cf_d = alu_carry; end
          OP_MOV_AI: begin sel = SEL_ZERO; im_o = imm; ld[0] = 1'b1; cf_d = 1'b0; end
          OP_MOV_BI: begin sel = SEL_ZERO; im_o = imm; ld[1] = 1'b1; cf_d = 1'b0; end
          OP_MOV_AB: begin sel = SEL_B;                ld[0] = 1'b1; cf_d = 1'b0; end
          OP_MOV_BA: begin sel = SEL_A;                ld[1] = 1'b1; cf_d = 1'b0; end
          OP_IN_A:   begin sel = SEL_C;                ld[0] = 1'b1; cf_d = 1'b0; end
          OP_OUT_I:  begin sel = SEL_ZERO; im_o = imm; ld[2] = 1'b1; cf_d = 1'b0; end
          OP_OUT_B:  begin sel = SEL_B;                ld[2] = 1'b1; cf_d = 1'b0; end
          OP_JMP:    pc_d = imm;
          OP_JNC:    if (!cf_q) pc_d = imm;
          default:   ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      pc_q    <= 4'h0;
      ir_q    <= 8'h00;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cf_q    <= cf_d;
    end
  end

  assign rom_addr   = pc_q;
  assign busy       = (state_q != IDLE);
  assign carry_flag = cf_q;
  assign im         = im_o;
  assign select_a   = sel[0];
  assign select_b   = sel[1];
  assign load0      = ld[0];
  assign load1      = ld[1];
  assign load2      = ld[2];
  assign load3      = ld[3];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed cases, then random programs run against an
// instruction-level model with a queue-based scoreboard and a small datapath.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       run = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       alu_carry;
  logic       select_a, select_b;
  logic       load0, load1, load2, load3;
  logic [3:0] im;
  logic       busy, carry_flag;

  cpu_sequencer dut (
    .clk(clk), .n_reset(n_reset), .run(run), .rom_addr(rom_addr),
    .rom_data(rom_data), .alu_carry(alu_carry), .select_a(select_a),
    .select_b(select_b), .load0(load0), .load1(load1), .load2(load2),
    .load3(load3), .im(im), .busy(busy), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [16];
  assign rom_data = rom[rom_addr];

  wire [3:0] loads = {load3, load2, load1, load0};
  wire [1:0] sel   = {select_b, select_a};

  // datapath environment: A, B, output port, C input, 4-bit adder
  logic       force_en = 1'b0, force_val = 1'b0;
  logic [3:0] c_in = 4'h0;
  logic [3:0] dp_a, dp_b, dp_out, dp_src;
  logic [4:0] dp_sum;
  always_comb begin
    dp_src = 4'h0;
    case (sel)
      2'b00:   dp_src = dp_a;
      2'b01:   dp_src = dp_b;
      2'b10:   dp_src = c_in;
      default: dp_src = 4'h0;
    endcase
    dp_sum = {1'b0, dp_src} + {1'b0, im};
  end
  assign alu_carry = force_en ? force_val : dp_sum[4];
  always @(posedge clk) begin
    if (!n_reset) begin
      dp_a <= 4'h0; dp_b <= 4'h0; dp_out <= 4'h0;
    end else begin
      if (load0) dp_a   <= dp_sum[3:0];
      if (load1) dp_b   <= dp_sum[3:0];
      if (load2) dp_out <= dp_sum[3:0];
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    run     = 1'b0;
    cyc();
    cyc();
    n_reset = 1'b1;
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] ld;
    logic [1:0] sel;
    logic [3:0] im;
    logic [3:0] nxt;
    logic       cf;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_pc, m_a, m_b, m_out;
  logic       m_cf;

  task automatic push_next();
    exp_t       e;
    logic [3:0] op, k, srcv, iv;
    logic [4:0] sum;
    logic [1:0] s;
    logic       ui, add;
    int         dst;
    op = rom[m_pc][7:4];
    k  = rom[m_pc][3:0];
    e = '0;
    e.pc = m_pc;
    s = 2'd0; ui = 1'b0; add = 1'b0; dst = -1;
    case (op)
      4'h0: begin s = 2'd0; ui = 1'b1; dst = 0; add = 1'b1; end
      4'h5: begin s = 2'd1; ui = 1'b1; dst = 1; add = 1'b1; end
      4'h3: begin s = 2'd3; ui = 1'b1; dst = 0; end
      4'h7: begin s = 2'd3; ui = 1'b1; dst = 1; end
      4'h1: begin s = 2'd1; dst = 0; end
      4'h4: begin s = 2'd0; dst = 1; end
      4'h2: begin s = 2'd2; dst = 0; end
      4'hB: begin s = 2'd3; ui = 1'b1; dst = 2; end
      4'h9: begin s = 2'd1; dst = 2; end
      default: ;
    endcase
    e.nxt = m_pc + 4'd1;
    if (op == 4'hF) e.nxt = k;
    if (op == 4'hE && !m_cf) e.nxt = k;
    if (dst >= 0) begin
      srcv = (s == 2'd0) ? m_a : (s == 2'd1) ? m_b : (s == 2'd2) ? c_in : 4'h0;
      iv   = ui ? k : 4'h0;
      sum  = {1'b0, srcv} + {1'b0, iv};
      e.sel = s;
      e.im  = iv;
      e.ld[dst] = 1'b1;
      if (dst == 0) m_a = sum[3:0];
      else if (dst == 1) m_b = sum[3:0];
      else m_out = sum[3:0];
      m_cf = add ? sum[4] : 1'b0;
    end
    e.cf = m_cf;
    m_pc = e.nxt;
    q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic mon_en = 1'b0;
  int   pops = 0;
  initial begin : monitor
    exp_t cur;
    logic ph, pend;
    ph = 1'b0; pend = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          chk("sb_next_pc", rom_addr, cur.nxt);
          chk("sb_carry_flag", carry_flag, cur.cf);
          pend = 1'b0;
        end
        if (!busy) ph = 1'b0;
        else begin
          if (ph) begin
            if (q.size() == 0) begin
              checks++; fails++;
              $display("FAIL sb_unexpected_exec: pc %0h with no expected entry", rom_addr);
            end else begin
              cur = q.pop_front();
              chk("sb_exec_pc", rom_addr, cur.pc);
              chk("sb_loads", loads, cur.ld);
              if (cur.ld != 4'b0000) begin
                chk("sb_select", sel, cur.sel);
                chk("sb_im", im, cur.im);
              end
              pend = 1'b1;
              pops++;
            end
          end
          ph = ~ph;
        end
      end else begin
        ph = 1'b0; pend = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    cyc();
    do_reset();
    chk("rst_rom_addr", rom_addr, 4'h0);
    chk("rst_loads", loads, 4'h0);
    chk("rst_im", im, 4'h0);
    chk("rst_select", sel, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cf", carry_flag, 1'b0);
    cyc();
    chk("idle_hold_busy", busy, 1'b0);

    // MOV A,5
    rom[0] = 8'h35;
    run = 1'b1;
    cyc();
    chk("mov_fetch_busy", busy, 1'b1);
    chk("mov_fetch_addr", rom_addr, 4'h0);
    chk("mov_fetch_loads", loads, 4'h0);
    cyc();
    chk("mov_exec_loads", loads, 4'b0001);
    chk("mov_exec_sel", sel, 2'b11);
    chk("mov_exec_im", im, 4'h5);
    cyc();
    chk("mov_pc", rom_addr, 4'h1);
    chk("mov_after_loads", loads, 4'h0);

    // ADD A,15 with carry, then JNC 7 not taken
    do_reset();
    rom[0] = 8'h0F; rom[1] = 8'hE7;
    force_en = 1'b1; force_val = 1'b1;
    run = 1'b1;
    cyc(); cyc();
    chk("add_exec_loads", loads, 4'b0001);
    chk("add_exec_sel", sel, 2'b00);
    chk("add_exec_im", im, 4'hF);
    cyc();
    chk("add_cf_set", carry_flag, 1'b1);
    cyc();
    chk("jnc_exec_loads", loads, 4'h0);
    cyc();
    chk("jnc_not_taken_pc", rom_addr, 4'h2);

    // ADD sets CF, MOV clears it, JNC 7 taken
    do_reset();
    rom[0] = 8'h0F; rom[1] = 8'h39; rom[2] = 8'hE7;
    run = 1'b1;
    cyc(); cyc(); cyc();
    chk("add2_cf_set", carry_flag, 1'b1);
    cyc(); cyc();
    chk("mov_cf_clear", carry_flag, 1'b0);
    cyc(); cyc();
    chk("jnc_taken_pc", rom_addr, 4'h7);
    force_en = 1'b0;

    // PC wrap: JMP 15, NOP at 15
    do_reset();
    rom[0] = 8'hFF; rom[15] = 8'h80;
    run = 1'b1;
    cyc(); cyc(); cyc();
    chk("jmp15_pc", rom_addr, 4'hF);
    cyc(); cyc();
    chk("wrap_pc", rom_addr, 4'h0);
    chk("nop_cf_kept", carry_flag, 1'b0);

    // run dropped during FETCH of ADD B,3
    do_reset();
    rom[0] = 8'h53; rom[15] = 8'h80;
    run = 1'b1;
    cyc();
    run = 1'b0;
    cyc();
    chk("drop_exec_loads", loads, 4'b0010);
    chk("drop_exec_sel", sel, 2'b01);
    chk("drop_exec_im", im, 4'h3);
    cyc();
    chk("drop_idle_busy", busy, 1'b0);
    chk("drop_idle_pc", rom_addr, 4'h1);
    cyc();
    chk("drop_hold_pc", rom_addr, 4'h1);
    chk("drop_hold_busy", busy, 1'b0);

    // reset during EXEC of JMP 9
    do_reset();
    rom[0] = 8'h0F; rom[1] = 8'hF9;
    force_en = 1'b1; force_val = 1'b1;
    run = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_rst_cf", carry_flag, 1'b1);
    cyc();
    n_reset = 1'b0;
    cyc();
    chk("midrst_pc", rom_addr, 4'h0);
    chk("midrst_cf", carry_flag, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    n_reset = 1'b1;
    run = 1'b0;
    force_en = 1'b0;
    cyc();
    chk("midrst_idle_loads", loads, 4'h0);
    chk("midrst_idle_busy", busy, 1'b0);
    chk("midrst_idle_pc", rom_addr, 4'h0);

    // random programs against the instruction-level model
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      c_in = 4'($urandom);
      do_reset();
      m_pc = 4'h0; m_a = 4'h0; m_b = 4'h0; m_out = 4'h0; m_cf = 1'b0;
      q.delete();
      pops = 0;
      for (int i = 0; i < 3; i++) push_next();
      mon_en = 1'b1;
      for (int cy = 0; cy < 4000 && pops < 60; cy++) begin
        cyc();
        while (q.size() < 3) push_next();
        run = ($urandom_range(0, 3) != 0);
      end
      run = 1'b0;
      for (int w = 0; w < 6 && busy; w++) cyc();
      cyc(); cyc();
      mon_en = 1'b0;
      if (pops < 60) begin
        checks++; fails++;
        $display("FAIL rand_timeout: executed %0d instructions, wanted 60", pops);
      end
      chk("rand_drain_busy", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock; all state updates on posedge clk.
REQ-002 SHALL have port n_reset, input, 1: reset n_reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port run, input, 1: start/continue execution when high.
REQ-004 SHALL have port rom_addr, output, 4: program ROM address, equal to PC at all times.
REQ-005 SHALL have port rom_data, input, 8: instruction from combinational ROM; [7:4] opcode, [3:0] immediate.
REQ-006 SHALL have port alu_carry, input, 1: carry-out of datapath 4-bit adder, valid in EXEC.
REQ-007 SHALL have ports select_a and select_b, output, 1 each: datapath source select {select_b,select_a}: 00 A, 01 B, 10 C (input port), 11 zero.
REQ-008 SHALL have ports load0, load1, load2 and load3, output, 1 each: write strobes for A, B, C (output port) and D.
REQ-009 SHALL have port im, output, 4: immediate to the ALU adder.
REQ-010 SHALL have port busy, output, 1: high in FETCH or EXEC.
REQ-011 SHALL have port carry_flag, output, 1: current carry flag.

Function
REQ-012 SHALL implement states IDLE, FETCH and EXEC, with internal registers PC[3:0], IR[7:0] and CF.
REQ-013 SHALL transition IDLE->FETCH when run=1, and stay in IDLE when run=0.
REQ-014 SHALL, in FETCH, latch IR<=rom_data and transition unconditionally to EXEC; every instruction takes exactly 2 cycles.
REQ-015 SHALL, in EXEC, transition to FETCH if run=1, else to IDLE; a run drop mid-instruction completes the current EXEC.
REQ-016 SHALL drive load0-3 only in EXEC and only for one cycle per instruction; outside EXEC all loads=0, im=0 and select=00.
REQ-017 SHALL decode the EXEC opcode (IR[7:4]) as follows (source select / im / load):
- 0000 ADD A,Im: select A / IR[3:0] / load0.
- 0101 ADD B,Im: select B / IR[3:0] / load1.
- 0011 MOV A,Im: select zero / IR[3:0] / load0.
- 0111 MOV B,Im: select zero / IR[3:0] / load1.
- 0001 MOV A,B: select B / 0 / load0.
- 0100 MOV B,A: select A / 0 / load1.
- 0010 IN A: select C / 0 / load0.
- 1011 OUT Im: select zero / IR[3:0] / load2.
- 1001 OUT B: select B / 0 / load2.
- 1111 JMP Im: no load; PC<=IR[3:0].
- 1110 JNC Im: no load; PC<=IR[3:0] if CF=0, else PC+1.
- all other codes: NOP, no load.
REQ-018 SHALL update PC only at the end of EXEC: jump target if taken, else PC+1 mod 16 (15 wraps to 0).
REQ-019 SHALL set CF<=alu_carry at the end of EXEC for ADD A and ADD B.
REQ-020 SHALL clear CF at the end of EXEC for MOV, IN and OUT.
REQ-021 SHALL leave CF unchanged for JMP, JNC and NOP.
REQ-022 SHALL have JNC test CF as it stood before the current EXEC edge.
REQ-023 SHALL decode load and select outputs combinationally from state and IR, so the datapath captures on the same edge that ends EXEC.
REQ-024 SHALL guarantee that at most one of load0-3 is high in any cycle; load3 is never asserted by the current opcode set.

Reset
REQ-025 SHALL, when n_reset=0 at posedge, set state=IDLE, PC=0, IR=0x00 and CF=0, overriding run and any in-flight instruction.
REQ-026 SHALL, during and after reset until the first EXEC, drive rom_addr=0, all loads=0, im=0, select=00, busy=0 and carry_flag=0.
REQ-027 SHALL, when reset is asserted during EXEC, suppress that instruction's PC and CF update; datapath strobes, being combinational, are not guaranteed suppressed.

Verification
REQ-028 SHALL verify reset then run=1 with ROM[0]=0x35 (MOV A,5): cycle 1 FETCH rom_addr=0; cycle 2 load0=1, select=11, im=5; then PC=1.
REQ-029 SHALL verify ROM[0]=0x0F (ADD A,15) with alu_carry=1 in EXEC, then ROM[1]=0xE7 (JNC 7): CF=1, jump not taken, PC=2.
REQ-030 SHALL verify ROM[0]=0x39 (MOV clears CF), then ROM[1]=0xE7: jump taken, PC=7.
REQ-031 SHALL verify PC=15 executing NOP: PC wraps to 0, rom_addr=0.
REQ-032 SHALL verify run dropped during FETCH of ADD B,3: EXEC still issues load1 with select=01 and im=3, then the block enters IDLE with busy=0 and PC held.
REQ-033 SHALL verify n_reset=0 during EXEC of JMP 9: PC=0, CF=0, state IDLE next cycle, and no load asserted after reset.
